// File: rtl/eth_baser_pkg.sv
// Shared types and helpers for the BASE-R receive path.
package eth_baser_pkg;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_baser_ber_mon.sv
// 125 us BER window: counts invalid headers while locked and flags high BER.
module eth_phy_baser_ber_mon #(
  parameter int unsigned COUNT_125US = 19531,
  parameter int unsigned BER_LIMIT   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hdr_strobe,
  input  logic hdr_invalid,
  input  logic block_lock,
  input  logic block_lock_next,
  output logic rx_high_ber,
  output logic high_ber_next_c
);

  localparam int unsigned TIMER_W = $clog2(COUNT_125US + 1);
  localparam int unsigned BER_W   = $clog2(BER_LIMIT + 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [BER_W-1:0]   ber_cnt_q, ber_cnt_d, ber_inc;

  // Clearing keys off the next lock value so high BER drops together with lock.
  always_comb begin
    timer_d         = timer_q;
    ber_cnt_d       = ber_cnt_q;
    high_ber_next_c = rx_high_ber;
    ber_inc         = ber_cnt_q;
    if (hdr_strobe && hdr_invalid && (ber_cnt_q < BER_W'(BER_LIMIT)))
      ber_inc = ber_cnt_q + 1'b1;

    if (!block_lock_next) begin
      timer_d         = '0;
      ber_cnt_d       = '0;
      high_ber_next_c = 1'b0;
    end else if (block_lock) begin
      if (timer_q == TIMER_W'(COUNT_125US - 1)) begin
        timer_d         = '0;
        ber_cnt_d       = '0;
        high_ber_next_c = (ber_inc == BER_W'(BER_LIMIT));
      end else begin
        timer_d   = timer_q + 1'b1;
        ber_cnt_d = ber_inc;
        if (ber_inc == BER_W'(BER_LIMIT))
          high_ber_next_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q     <= '0;
      ber_cnt_q   <= '0;
      rx_high_ber <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      ber_cnt_q   <= ber_cnt_d;
      rx_high_ber <= high_ber_next_c;
    end
  end

endmodule

// File: rtl/eth_phy_baser_rx_sync.sv
// BASE-R 64b/66b block synchroniser with bitslip control, lock/error counters and BER monitor.
module eth_phy_baser_rx_sync
  import eth_baser_pkg::*;
#(
  parameter int unsigned LOCK_COUNT          = 64,
  parameter int unsigned WINDOW_COUNT        = 64,
  parameter int unsigned INVALID_LIMIT       = 16,
  parameter int unsigned BITSLIP_HIGH_CYCLES = 1,
  parameter int unsigned BITSLIP_LOW_CYCLES  = 8,
  parameter int unsigned COUNT_125US         = 19531,
  parameter int unsigned BER_LIMIT           = 16,
  parameter int unsigned ERR_CNT_WIDTH       = 7,
  parameter int unsigned LOSS_CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                serdes_rx_hdr,
  input  logic                      serdes_rx_hdr_valid,
  input  logic                      relock_req,
  input  logic                      clr_counters,
  output logic                      serdes_rx_bitslip,
  output logic                      rx_block_lock,
  output logic                      rx_high_ber,
  output logic [ERR_CNT_WIDTH-1:0]  rx_error_count,
  output logic [LOSS_CNT_WIDTH-1:0] rx_lock_loss_count,
  output logic                      rx_status_change
);

  localparam int unsigned SH_W   = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W  = $clog2(WINDOW_COUNT + 1);
  localparam int unsigned INV_W  = $clog2(INVALID_LIMIT + 1);
  localparam int unsigned SLIP_N = BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES;
  localparam int unsigned SLIP_W = $clog2(SLIP_N + 1);

  sync_state_t       state_q, state_d;
  logic [SH_W-1:0]   sh_cnt_q, sh_cnt_d, sh_inc;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d, win_inc;
  logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d, inv_inc;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d, slip_inc;
  logic              bitslip_d, lock_d, loss_inc, err_inc, hdr_ok, high_ber_next;

  assign hdr_ok   = hdr_valid(serdes_rx_hdr);
  assign sh_inc   = sh_cnt_q + 1'b1;
  assign win_inc  = win_cnt_q + 1'b1;
  assign inv_inc  = inv_cnt_q + INV_W'(!hdr_ok);
  assign slip_inc = slip_cnt_q + 1'b1;
  assign err_inc  = (state_q == LOCKED) && serdes_rx_hdr_valid && !hdr_ok;

  always_comb begin
    state_d    = state_q;
    sh_cnt_d   = sh_cnt_q;
    win_cnt_d  = win_cnt_q;
    inv_cnt_d  = inv_cnt_q;
    slip_cnt_d = slip_cnt_q;
    bitslip_d  = 1'b0;
    lock_d     = rx_block_lock;
    loss_inc   = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (serdes_rx_hdr_valid) begin
          if (!hdr_ok) begin
            state_d    = SLIP;
            sh_cnt_d   = '0;
            slip_cnt_d = '0;
            bitslip_d  = 1'b1;
          end else if (sh_inc == SH_W'(LOCK_COUNT)) begin
            state_d   = LOCKED;
            lock_d    = 1'b1;
            sh_cnt_d  = '0;
            win_cnt_d = '0;
            inv_cnt_d = '0;
          end else begin
            sh_cnt_d = sh_inc;
          end
        end
      end
      // Headers are ignored for the whole slip pulse plus settle time.
      SLIP: begin
        if (slip_inc == SLIP_W'(SLIP_N)) begin
          state_d    = HUNT;
          sh_cnt_d   = '0;
          slip_cnt_d = '0;
        end else begin
          slip_cnt_d = slip_inc;
          bitslip_d  = (slip_inc < SLIP_W'(BITSLIP_HIGH_CYCLES));
        end
      end
      LOCKED: begin
        if (serdes_rx_hdr_valid) begin
          if (inv_inc == INV_W'(INVALID_LIMIT)) begin
            state_d    = SLIP;
            lock_d     = 1'b0;
            loss_inc   = 1'b1;
            win_cnt_d  = '0;
            inv_cnt_d  = '0;
            slip_cnt_d = '0;
            bitslip_d  = 1'b1;
          end else if (win_inc == WIN_W'(WINDOW_COUNT)) begin
            win_cnt_d = '0;
            inv_cnt_d = '0;
          end else begin
            win_cnt_d = win_inc;
            inv_cnt_d = inv_inc;
          end
        end
      end
      default: state_d = HUNT;
    endcase
    // Software relock overrides everything, including a same-cycle lock loss.
    if (relock_req) begin
      state_d    = HUNT;
      sh_cnt_d   = '0;
      win_cnt_d  = '0;
      inv_cnt_d  = '0;
      slip_cnt_d = '0;
      bitslip_d  = 1'b0;
      lock_d     = 1'b0;
      loss_inc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= HUNT;
      sh_cnt_q          <= '0;
      win_cnt_q         <= '0;
      inv_cnt_q         <= '0;
      slip_cnt_q        <= '0;
      serdes_rx_bitslip <= 1'b0;
      rx_block_lock     <= 1'b0;
      rx_status_change  <= 1'b0;
    end else begin
      state_q           <= state_d;
      sh_cnt_q          <= sh_cnt_d;
      win_cnt_q         <= win_cnt_d;
      inv_cnt_q         <= inv_cnt_d;
      slip_cnt_q        <= slip_cnt_d;
      serdes_rx_bitslip <= bitslip_d;
      rx_block_lock     <= lock_d;
      rx_status_change  <= (lock_d != rx_block_lock) || (high_ber_next != rx_high_ber);
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_error_count     <= '0;
      rx_lock_loss_count <= '0;
    end else if (clr_counters) begin
      rx_error_count     <= '0;
      rx_lock_loss_count <= '0;
    end else begin
      if (err_inc && (rx_error_count != '1))
        rx_error_count <= rx_error_count + 1'b1;
      if (loss_inc && (rx_lock_loss_count != '1))
        rx_lock_loss_count <= rx_lock_loss_count + 1'b1;
    end
  end

  eth_phy_baser_ber_mon #(
    .COUNT_125US (COUNT_125US),
    .BER_LIMIT   (BER_LIMIT)
  ) u_ber_mon (
    .clk             (clk),
    .rst_n           (rst_n),
    .hdr_strobe      (serdes_rx_hdr_valid),
    .hdr_invalid     (!hdr_ok),
    .block_lock      (rx_block_lock),
    .block_lock_next (lock_d),
    .rx_high_ber     (rx_high_ber),
    .high_ber_next_c (high_ber_next)
  );

endmodule
